// File: rtl/contador_descendente_pkg.sv
// Shared constants and state encoding for the down-counter and the mod-28 up-counter.
// The optional auto-reload feature of contador_descendente is selected with RECARGA_AUTO_EN.
package contador_descendente_pkg;

    localparam int ANCHO_DEF      = 5;
    localparam int CUENTA_MAX_DEF = 27;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        CUENTA = 2'b01,
        FIN    = 2'b10
    } estado_t;

endpackage

// File: rtl/contador_descendente.sv
// Loadable down-counter with a one-cycle terminal strobe; define RECARGA_AUTO_EN to make
// FIN reload the latched start value and keep counting until cancel or reset.
module contador_descendente
    import contador_descendente_pkg::*;
#(
    parameter int ANCHO      = ANCHO_DEF,
    parameter int CUENTA_MAX = CUENTA_MAX_DEF
) (
    input  logic             clk,
    input  logic             reset_clk,
    input  logic             start,
    input  logic [ANCHO-1:0] valor_carga,
    input  logic             enable,
    input  logic             cancel,
    output logic [ANCHO-1:0] cuenta,
    output logic             ocupado,
    output logic             fin,
    output estado_t          estado_dbg
);

    localparam logic [ANCHO-1:0] MAX_V = ANCHO'(CUENTA_MAX);
    localparam logic [ANCHO-1:0] UNO   = ANCHO'(1);

    // Handshake: start is a one-cycle request, accepted only while ocupado is low (IDLE)
    // and cancel is low; there is no separate ready, a start seen while busy is dropped.
    estado_t          estado, estado_next;
    logic [ANCHO-1:0] cuenta_next;
    logic [ANCHO-1:0] carga;

`ifdef RECARGA_AUTO_EN
    logic [ANCHO-1:0] recarga, recarga_next;
`endif

    assign carga      = (valor_carga > MAX_V) ? MAX_V : valor_carga;
    assign estado_dbg = estado;

    always_ff @(posedge clk or negedge reset_clk) begin
        if (!reset_clk) begin
            estado  <= IDLE;
            cuenta  <= '0;
            fin     <= 1'b0;
            ocupado <= 1'b0;
`ifdef RECARGA_AUTO_EN
            recarga <= '0;
`endif
        end else begin
            estado  <= estado_next;
            cuenta  <= cuenta_next;
            fin     <= (estado_next == FIN);
            ocupado <= (estado_next != IDLE);
`ifdef RECARGA_AUTO_EN
            recarga <= recarga_next;
`endif
        end
    end

    always_comb begin
        estado_next = estado;
        cuenta_next = cuenta;
`ifdef RECARGA_AUTO_EN
        recarga_next = recarga;
`endif
        case (estado)
            IDLE: begin
                cuenta_next = '0;
                if (start && !cancel) begin
`ifdef RECARGA_AUTO_EN
                    recarga_next = carga;
`endif
                    cuenta_next = carga;
                    estado_next = (carga == '0) ? FIN : CUENTA;
                end
            end
            CUENTA: begin
                if (cancel) begin
                    estado_next = IDLE;
                    cuenta_next = '0;
                end else if (enable) begin
                    // cuenta is never 0 here, but <= keeps the path from ever wrapping
                    if (cuenta <= UNO) begin
                        estado_next = FIN;
                        cuenta_next = '0;
                    end else begin
                        cuenta_next = cuenta - UNO;
                    end
                end
            end
            FIN: begin
                cuenta_next = '0;
                if (cancel) begin
                    estado_next = IDLE;
                end else begin
`ifdef RECARGA_AUTO_EN
                    if (recarga != '0) begin
                        estado_next = CUENTA;
                        cuenta_next = recarga;
                    end else begin
                        estado_next = FIN;
                    end
`else
                    estado_next = IDLE;
`endif
                end
            end
            default: begin
                estado_next = IDLE;
                cuenta_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_contador_descendente.sv
// Directed plus random bench for contador_descendente with an expected-value queue.
module tb_contador_descendente;
    import contador_descendente_pkg::*;

    localparam int W = ANCHO_DEF + 4;

    logic                 clk;
    logic                 reset_clk;
    logic                 start;
    logic [ANCHO_DEF-1:0] valor_carga;
    logic                 enable;
    logic                 cancel;
    logic [ANCHO_DEF-1:0] cuenta;
    logic                 ocupado;
    logic                 fin;
    estado_t              estado_dbg;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model, written from the behavioural description
    bit m_busy;
    bit m_fin;
    int m_cnt;
    int m_reload;

    contador_descendente dut (
        .clk        (clk),
        .reset_clk  (reset_clk),
        .start      (start),
        .valor_carga(valor_carga),
        .enable     (enable),
        .cancel     (cancel),
        .cuenta     (cuenta),
        .ocupado    (ocupado),
        .fin        (fin),
        .estado_dbg (estado_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_fin = 0; m_cnt = 0; m_reload = 0;
    endtask

    task automatic model_edge(input bit s, input int v, input bit e, input bit c);
        int vc;
        if (!m_busy) begin
            if (s && !c) begin
                vc = (v > CUENTA_MAX_DEF) ? CUENTA_MAX_DEF : v;
                m_reload = vc;
                m_busy = 1;
                m_cnt = vc;
                m_fin = (vc == 0);
            end
        end else if (c) begin
            m_busy = 0; m_cnt = 0; m_fin = 0;
        end else if (m_fin) begin
`ifdef RECARGA_AUTO_EN
            if (m_reload > 0) begin
                m_fin = 0; m_cnt = m_reload;
            end
`else
            m_busy = 0; m_fin = 0;
`endif
        end else if (e) begin
            if (m_cnt == 1) begin
                m_cnt = 0; m_fin = 1;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    function automatic logic [W-1:0] model_word();
        logic [1:0] st;
        st = !m_busy ? 2'b00 : (m_fin ? 2'b10 : 2'b01);
        return {m_cnt[ANCHO_DEF-1:0], logic'(m_busy), logic'(m_fin), st};
    endfunction

    // scoreboard
    task automatic check(input string tag);
        logic [W-1:0] exp_w;
        logic [W-1:0] obs_w;
        obs_w = {cuenta, ocupado, fin, estado_dbg};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s obs=%h exp=<empty queue>", tag, obs_w);
        end else begin
            exp_w = exp_q.pop_front();
            assert (obs_w === exp_w) else begin
                n_err++;
                $error("FAIL %s obs{cuenta,ocupado,fin,estado}=%h exp=%h", tag, obs_w, exp_w);
            end
        end
    endtask

    // driver
    task automatic step(input string tag, input bit s, input int v, input bit e, input bit c);
        start = s; valor_carga = v[ANCHO_DEF-1:0]; enable = e; cancel = c;
        model_edge(s, v, e, c);
        exp_q.push_back(model_word());
        @(posedge clk);
        #1;
        check(tag);
        start = 1'b0; cancel = 1'b0;
    endtask

    task automatic run(input string tag, input int n, input bit e);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 0, e, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset_clk = 1'b0;
        model_reset();
        exp_q.push_back(model_word());
        #1;
        check(tag);
        @(negedge clk);
        reset_clk = 1'b1;
    endtask

    initial begin
        reset_clk = 1'b0; start = 1'b0; valor_carga = '0; enable = 1'b0; cancel = 1'b0;
        model_reset();
        #3;
        exp_q.push_back(model_word());
        check("reset_state");
        @(negedge clk);
        reset_clk = 1'b1;

        // load 5, count 5..0 with a single fin, then idle
        step("load5", 1'b1, 5, 1'b1, 1'b0);
        run("cnt5", 6, 1'b1);

        // out-of-range load clamps to 27
        step("load31", 1'b1, 31, 1'b1, 1'b0);
        run("cnt27", 28, 1'b1);

        // zero load goes straight to FIN
        step("load0", 1'b1, 0, 1'b0, 1'b0);
        run("after0", 2, 1'b0);

        // enable gaps and an ignored start while counting
        step("load6", 1'b1, 6, 1'b1, 1'b0);
        run("cnt6", 2, 1'b1);
        run("hold", 3, 1'b0);
        run("cnt6b", 1, 1'b1);
        step("busy_start", 1'b1, 20, 1'b1, 1'b0);
        run("cnt6c", 4, 1'b1);

        // cancel beats start
        step("load10", 1'b1, 10, 1'b1, 1'b0);
        run("cnt10", 3, 1'b1);
        step("cancel_start", 1'b1, 9, 1'b1, 1'b1);
        run("after_cancel", 2, 1'b1);
        step("cancel_idle", 1'b0, 0, 1'b1, 1'b1);

        // asynchronous reset mid-count
        step("load10r", 1'b1, 10, 1'b1, 1'b0);
        run("cnt10r", 7, 1'b1);
        async_reset("async_reset");
        step("restart", 1'b1, 2, 1'b1, 1'b0);
        run("cnt2", 4, 1'b1);

`ifdef RECARGA_AUTO_EN
        step("auto_load3", 1'b1, 3, 1'b1, 1'b0);
        run("auto_cnt", 12, 1'b1);
        step("auto_cancel", 1'b0, 0, 1'b1, 1'b1);
        run("auto_idle", 2, 1'b1);
`endif

        // random traffic
        for (int i = 0; i < 200; i++) begin
            step("random", $urandom_range(0, 5) == 0, int'($urandom_range(0, 31)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/contador_descendente.md
CONTADOR_DESCENDENTE -- requirements
Module: contador_descendente

Interface
REQ-001 Parameter ANCHO, default 5, width in bits of the count path.
REQ-002 Parameter CUENTA_MAX, default 27, largest loadable count; matches the mod-28 up-counter range.
REQ-003 clk  input  1  rising-edge system clock, the only clock.
REQ-004 reset_clk  input  1  asynchronous reset, active-low (0 = reset).
REQ-005 start  input  1  request to load valor_carga and begin counting down.
REQ-006 valor_carga  input  ANCHO  start value, sampled only on an accepted start.
REQ-007 enable  input  1  count-advance qualifier; 0 holds the count.
REQ-008 cancel  input  1  synchronous abort of the current count.
REQ-009 cuenta  output  ANCHO  current count value, registered.
REQ-010 ocupado  output  1  high while in state CUENTA or FIN.
REQ-011 fin  output  1  one-cycle terminal-count strobe, registered.

Function
REQ-012 FSM states: IDLE, CUENTA, FIN.
REQ-013 IDLE outputs: cuenta=0, ocupado=0, fin=0.
REQ-014 Start acceptance: start=1 in IDLE is accepted at that edge; start in CUENTA or FIN is ignored and has no effect.
REQ-015 Loaded value: clamped to min(valor_carga, CUENTA_MAX); the clamped value is latched as the reload value.
REQ-016 Start with clamped value 0: go directly to FIN with cuenta=0.
REQ-017 Start with clamped value V>0: go to CUENTA with cuenta=V after the same edge.
REQ-018 CUENTA, enable=1: cuenta decrements by 1 per edge.
REQ-019 CUENTA, enable=0: cuenta and state hold.
REQ-020 CUENTA, cuenta=1 and enable=1: go to FIN with cuenta=0 (no underflow or wrap below 0, ever).
REQ-021 Latency: with enable held 1, fin is high exactly in the cycle following edge N+V, where the accepted start is at edge N.
REQ-022 FIN: fin=1 and ocupado=1 for exactly one cycle, independent of enable.
REQ-023 FIN exit: next edge goes to IDLE (behaviour with RECARGA_AUTO_EN defined: see REQ-030).
REQ-024 cancel=1 in CUENTA or FIN: go to IDLE with cuenta=0, and fin is not asserted in the following cycle.
REQ-025 cancel and start in the same cycle: cancel wins and start is dropped.
REQ-026 cancel in IDLE: no effect.

Reset
REQ-027 reset_clk=0 forces IDLE, cuenta=0, fin=0, ocupado=0 and reload value=0, immediately and without waiting for clk.
REQ-028 Reset asserted mid-count: aborts silently, with no fin pulse.
REQ-029 Reset release: the first edge after release may accept start.

Configuration
REQ-030 Macro RECARGA_AUTO_EN defined: FIN exits to CUENTA with cuenta = latched reload value when that value is >0, and stays in FIN, re-pulsing fin every cycle, when it is 0; only cancel or reset returns to IDLE; ocupado stays 1 throughout.
REQ-031 Macro RECARGA_AUTO_EN undefined: one-shot behaviour per REQ-023, and no reload register is inferred beyond that required for REQ-015.

Structure
REQ-032 Shared package/header holds ANCHO, CUENTA_MAX and the FSM state encodings (IDLE=2'b00, CUENTA=2'b01, FIN=2'b10); the mod-28 up-counter uses the same constants.
REQ-033 No sub-module: single module with a sequential block for state/cuenta/reload and a combinational next-state block.

Verification
REQ-034 Reset then start=1, valor_carga=5, enable=1 -> cuenta 5,4,3,2,1,0; fin high for one cycle at cuenta=0; ocupado low next cycle.
REQ-035 valor_carga=31 -> cuenta loads 27; fin after 27 enabled cycles.
REQ-036 valor_carga=0 -> next cycle fin=1, cuenta=0, then IDLE.
REQ-037 Load 6, enable low for 3 cycles at cuenta=4, and start pulsed at cuenta=3 -> cuenta holds at 4 while enable is low; start is ignored; fin comes 9 cycles after load.
REQ-038 Load 10, then cancel+start together at cuenta=7 -> IDLE, cuenta=0, no fin; separately, reset_clk=0 at cuenta=3 -> immediate zero outputs, no fin.
REQ-039 Macro RECARGA_AUTO_EN defined, load 3 -> fin every 4 cycles repeatedly, and ocupado stays 1 until cancel.
